id_ex_stage: RTL and testbench

ID/EX pipeline stage for the 5-stage MIPS core. It sits directly downstream of the opcode control decoder and captures that decoder's packed 10-bit control word together with the decoded operands, then presents them to EX one cycle later. It also performs load-use hazard detection: it stalls PC and IF/ID and inserts a bubble. It squashes its contents when MEM resolves a taken branch or jump, and it keeps a saturating stall counter for bring-up.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/hazard_detect.sv | 23 ++
 rtl/id_ex_stage.sv | 112 +++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: control word layout and opcodes.
package mips_pkg;

    localparam int CTRL_W        = 10;

    // Bit positions inside the packed control word produced by the decoder.
    localparam int CTRL_REGDST   = 9;
    localparam int CTRL_ALUOP_HI = 8;
    localparam int CTRL_ALUOP_LO = 7;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_JUMP     = 5;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;

    // Primary opcodes understood by the control decoder.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // True when a control word describes a load (used by hazard logic).
    function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: compares the load sitting in ID/EX against the
// source specifiers of the instruction currently in IF/ID.
module hazard_detect (
    input  logic       i_valid_q,
    input  logic       i_memread_q,
    input  logic [4:0] i_rt_q,
    input  logic       i_valid_in,
    input  logic [4:0] i_rs_in,
    input  logic [4:0] i_rt_in,
    input  logic       i_flush_in,
    output logic       o_hazard,
    output logic       o_stall
);

    // A load into $0 never creates a dependency; a flush cancels the stall
    // because the dependent instruction is being squashed anyway.
    always_comb begin
        o_hazard = i_valid_q & i_memread_q & (i_rt_q != 5'd0) & i_valid_in &
                   ((i_rt_q == i_rs_in) | (i_rt_q == i_rt_in));
        o_stall  = o_hazard & ~i_flush_in;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch/jump flush
// and a saturating bring-up counter of inserted hazard bubbles.
//
// Valid semantics: valid_in marks a real instruction in IF/ID; valid_out marks
// a real instruction in ID/EX. There is no ready: upstream honours stall_out by
// holding PC and IF/ID, so the same instruction is re-presented next cycle.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW  = 32,
    parameter int CW  = CTRL_W,
    parameter int SCW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] ctrl_in,
    input  logic          valid_in,
    input  logic [DW-1:0] pc4_in,
    input  logic [DW-1:0] rd1_in,
    input  logic [DW-1:0] rd2_in,
    input  logic [DW-1:0] imm_in,
    input  logic [4:0]    rs_in,
    input  logic [4:0]    rt_in,
    input  logic [4:0]    rd_in,
    input  logic          flush_in,
    output logic [CW-1:0] ctrl_out,
    output logic          valid_out,
    output logic [DW-1:0] pc4_out,
    output logic [DW-1:0] rd1_out,
    output logic [DW-1:0] rd2_out,
    output logic [DW-1:0] imm_out,
    output logic [4:0]    rs_out,
    output logic [4:0]    rt_out,
    output logic [4:0]    rd_out,
    output logic          stall_out,
    output logic [SCW-1:0] stall_count
);

    logic [CW-1:0]  r_ctrl;
    logic           r_valid;
    logic [DW-1:0]  r_pc4;
    logic [DW-1:0]  r_rd1;
    logic [DW-1:0]  r_rd2;
    logic [DW-1:0]  r_imm;
    logic [4:0]     r_rs;
    logic [4:0]     r_rt;
    logic [4:0]     r_rd;
    logic [SCW-1:0] r_stall_count;

    logic           w_hazard;
    logic           w_stall;

    hazard_detect u_hazard_detect (
        .i_valid_q   (r_valid),
        .i_memread_q (r_ctrl[CTRL_MEMREAD]),
        .i_rt_q      (r_rt),
        .i_valid_in  (valid_in),
        .i_rs_in     (rs_in),
        .i_rt_in     (rt_in),
        .i_flush_in  (flush_in),
        .o_hazard    (w_hazard),
        .o_stall     (w_stall)
    );

    // Pipeline register: reset > flush bubble > hazard bubble > capture.
    always_ff @(posedge clk) begin
        if (reset || flush_in || w_hazard) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
        end else begin
            // An empty slot carries no control so nothing downstream fires.
            r_ctrl  <= valid_in ? ctrl_in : '0;
            r_valid <= valid_in;
            r_pc4   <= pc4_in;
            r_rd1   <= rd1_in;
            r_rd2   <= rd2_in;
            r_imm   <= imm_in;
            r_rs    <= rs_in;
            r_rt    <= rt_in;
            r_rd    <= rd_in;
        end
    end

    // Count hazard bubbles only (flush bubbles excluded); stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (!flush_in && w_hazard && (r_stall_count != {SCW{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign ctrl_out    = r_ctrl;
    assign valid_out   = r_valid;
    assign pc4_out     = r_pc4;
    assign rd1_out     = r_rd1;
    assign rd2_out     = r_rd2;
    assign imm_out     = r_imm;
    assign rs_out      = r_rs;
    assign rt_out      = r_rt;
    assign rd_out      = r_rd;
    assign stall_out   = w_stall;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic, checked
// against a behavioural model of the stage. A second instance with a 2-bit
// counter exercises saturation alongside the default-width instance.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 10;

    // ---------------- clock / reset / inputs ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] ctrl_in;
    logic          valid_in;
    logic [DW-1:0] pc4_in, rd1_in, rd2_in, imm_in;
    logic [4:0]    rs_in, rt_in, rd_in;
    logic          flush_in;

    always #5 clk = ~clk;

    // ---------------- DUT outputs ----------------
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic          a_valid, b_valid;
    logic [DW-1:0] a_pc4, a_rd1, a_rd2, a_imm, b_pc4, b_rd1, b_rd2, b_imm;
    logic [4:0]    a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
    logic          a_stall, b_stall;
    logic [15:0]   a_cnt;
    logic [1:0]    b_cnt;

    id_ex_stage #(.DW(DW), .CW(CW), .SCW(16)) dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush_in(flush_in),
        .ctrl_out(a_ctrl), .valid_out(a_valid), .pc4_out(a_pc4),
        .rd1_out(a_rd1), .rd2_out(a_rd2), .imm_out(a_imm),
        .rs_out(a_rs), .rt_out(a_rt), .rd_out(a_rd),
        .stall_out(a_stall), .stall_count(a_cnt)
    );

    id_ex_stage #(.DW(DW), .CW(CW), .SCW(2)) dut_sat (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush_in(flush_in),
        .ctrl_out(b_ctrl), .valid_out(b_valid), .pc4_out(b_pc4),
        .rd1_out(b_rd1), .rd2_out(b_rd2), .imm_out(b_imm),
        .rs_out(b_rs), .rt_out(b_rt), .rd_out(b_rd),
        .stall_out(b_stall), .stall_count(b_cnt)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Holds what ID/EX must contain; a "slot" is either an instruction or empty.
    logic [CW-1:0] m_ctrl = '0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_pc4 = '0, m_rd1 = '0, m_rd2 = '0, m_imm = '0;
    logic [4:0]    m_rs = '0, m_rt = '0, m_rd = '0;
    int            m_cnt16 = 0;
    int            m_cnt2  = 0;

    // Does the instruction in IF/ID read the register a load in ID/EX is writing?
    function automatic bit load_use();
        bit is_load_slot;
        is_load_slot = m_valid && m_ctrl[3] && (m_rt != 0);
        return is_load_slot && valid_in && (rs_in == m_rt || rt_in == m_rt);
    endfunction

    // Model advances on each edge, then the DUT registers are compared to it.
    always @(posedge clk) begin
        bit lu;
        lu = load_use();
        if (reset) begin
            {m_ctrl, m_valid, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd} = '0;
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (flush_in || lu) begin
            {m_ctrl, m_valid, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd} = '0;
            if (!flush_in) begin
                m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
                m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
            end
        end else begin
            m_valid = valid_in;
            m_ctrl  = valid_in ? ctrl_in : '0;
            m_pc4 = pc4_in; m_rd1 = rd1_in; m_rd2 = rd2_in; m_imm = imm_in;
            m_rs = rs_in; m_rt = rt_in; m_rd = rd_in;
        end
        #1;
        exp_q.push_back({m_ctrl, m_valid, m_rs, m_rt, m_rd});
        chk("ctrl_out",  a_ctrl,  m_ctrl);
        chk("valid_out", a_valid, m_valid);
        chk("pc4_out",   a_pc4,   m_pc4);
        chk("rd1_out",   a_rd1,   m_rd1);
        chk("rd2_out",   a_rd2,   m_rd2);
        chk("imm_out",   a_imm,   m_imm);
        chk("specs_out", {a_rs, a_rt, a_rd}, {m_rs, m_rt, m_rd});
        chk("stall_count16", a_cnt, 64'(m_cnt16));
        chk("stall_count2",  b_cnt, 64'(m_cnt2));
        chk("sat_inst_ctrl", {b_ctrl, b_valid, b_rs, b_rt, b_rd},
                             exp_q.pop_front());
    end

    // ---------------- driver ----------------
    // Apply one cycle of IF/ID inputs away from the edge, then check stall_out.
    task automatic drive(input logic rst, input logic [CW-1:0] c, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [DW-1:0] d1, input logic fl);
        @(negedge clk);
        reset = rst; ctrl_in = c; valid_in = v;
        rs_in = rs; rt_in = rt; rd_in = rd;
        rd1_in = d1; rd2_in = $urandom; pc4_in = $urandom; imm_in = $urandom;
        flush_in = fl;
        #2;
        if (!rst) begin
            chk("stall_out",     a_stall, load_use() && !flush_in);
            chk("stall_out_sat", b_stall, load_use() && !flush_in);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    localparam logic [CW-1:0] C_RTYPE = 10'b1100000010;
    localparam logic [CW-1:0] C_LW    = 10'b0001001011;
    localparam logic [CW-1:0] C_ADDI  = 10'b0001000010;

    initial begin
        reset = 1'b1; ctrl_in = $urandom; valid_in = 1'b1;
        pc4_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
        rs_in = $urandom; rt_in = $urandom; rd_in = $urandom; flush_in = 1'b0;

        // Reset with random inputs for two cycles.
        drive(1'b1, CW'($urandom), 1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b0);
        after_edge();
        chk("reset_ctrl", a_ctrl, 0);
        chk("reset_valid", a_valid, 0);
        chk("reset_rd1", a_rd1, 0);
        chk("reset_cnt", a_cnt, 0);

        // Pass-through of an R-type.
        drive(1'b0, C_RTYPE, 1'b1, 5'd2, 5'd3, 5'd4, 32'h11, 1'b0);
        chk("pass_stall", a_stall, 0);
        after_edge();
        chk("pass_ctrl", a_ctrl, 10'b1100000010);
        chk("pass_valid", a_valid, 1);
        chk("pass_specs", {a_rs, a_rt, a_rd}, {5'd2, 5'd3, 5'd4});
        chk("pass_rd1", a_rd1, 32'h11);

        // Load-use: lw to $5 then addi reading $5.
        drive(1'b0, C_LW, 1'b1, 5'd1, 5'd5, 5'd0, 32'h0, 1'b0);
        drive(1'b0, C_ADDI, 1'b1, 5'd5, 5'd6, 5'd0, 32'h22, 1'b0);
        chk("lu_stall", a_stall, 1);
        after_edge();
        chk("lu_bubble_ctrl", a_ctrl, 0);
        chk("lu_bubble_valid", a_valid, 0);
        chk("lu_count", a_cnt, 1);
        drive(1'b0, C_ADDI, 1'b1, 5'd5, 5'd6, 5'd0, 32'h22, 1'b0);
        chk("lu_release", a_stall, 0);
        after_edge();
        chk("lu_addi_ctrl", a_ctrl, 10'b0001000010);
        chk("lu_addi_rs", a_rs, 5);

        // Load into $0 never stalls.
        drive(1'b0, C_LW, 1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 1'b0);
        drive(1'b0, C_ADDI, 1'b1, 5'd0, 5'd6, 5'd0, 32'h33, 1'b0);
        chk("zero_stall", a_stall, 0);
        after_edge();
        chk("zero_no_bubble", a_valid, 1);

        // Flush and hazard together: flush wins, count unchanged.
        drive(1'b0, C_LW, 1'b1, 5'd1, 5'd7, 5'd0, 32'h0, 1'b0);
        drive(1'b0, C_ADDI, 1'b1, 5'd7, 5'd8, 5'd0, 32'h44, 1'b1);
        chk("flush_stall", a_stall, 0);
        after_edge();
        chk("flush_valid", a_valid, 0);
        chk("flush_count", a_cnt, 1);

        // Saturation of the 2-bit counter over five hazard bubbles.
        drive(1'b1, '0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, C_LW, 1'b1, 5'd1, 5'd9, 5'd0, 32'h0, 1'b0);
            drive(1'b0, C_ADDI, 1'b1, 5'd9, 5'd2, 5'd0, 32'h0, 1'b0);
            after_edge();
            chk("sat_count", b_cnt, (k < 3) ? k + 1 : 3);
        end
        chk("sat_wide_count", a_cnt, 5);

        // Randomized traffic; small register range keeps hazards frequent.
        for (int i = 0; i < 600; i++) begin
            logic [CW-1:0] c;
            c = CW'($urandom);
            if ($urandom_range(0, 2) == 0) c[3] = 1'b1;
            drive(($urandom_range(0, 49) == 0), c, ($urandom_range(0, 4) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                  $urandom, ($urandom_range(0, 7) == 0));
        end
        after_edge();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
